// File: rtl/pc_next_unit_pkg.sv
// Shared types and defaults for the next-PC selection unit.
package pc_next_unit_pkg;

    localparam int PC_W_DEF        = 8;
    localparam int STACK_DEPTH_DEF = 4;

    typedef enum logic {
        RUN    = 1'b0,
        HALTED = 1'b1
    } state_e;

endpackage

// File: rtl/pc_next_unit_return_stack.sv
// LIFO return-address stack; push and pop never both take effect on one edge.
module return_stack
    import pc_next_unit_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH_DEF,
    parameter int W     = PC_W_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic [2:0]   depth,
    output logic         full,
    output logic         empty
);

    localparam logic [2:0] DEPTH_L = 3'(DEPTH);

    logic [W-1:0] mem_q [8];
    logic [W-1:0] mem_d [8];
    logic [2:0]   depth_q, depth_d;
    logic [2:0]   top_idx;

    assign full    = (depth_q == DEPTH_L);
    assign empty   = (depth_q == 3'd0);
    assign top_idx = depth_q - 3'd1;
    assign dout    = mem_q[top_idx];
    assign depth   = depth_q;

    always_comb begin
        mem_d   = mem_q;
        depth_d = depth_q;
        if (push && !pop && !full) begin
            mem_d[depth_q] = din;
            depth_d        = depth_q + 3'd1;
        end else if (pop && !push && !empty) begin
            depth_d = depth_q - 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) depth_q <= 3'd0;
        else       depth_q <= depth_d;
    end

    // Entry contents are don't-care after reset, so no reset term here.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/pc_next_unit.sv
// Next-PC select with halt/resume FSM and a return-address stack.
module pc_next_unit
    import pc_next_unit_pkg::*;
#(
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int PC_W        = PC_W_DEF
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pc,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_offset,
    input  logic            jump,
    input  logic [PC_W-1:0] jump_target,
    input  logic            call,
    input  logic            ret,
    input  logic            halt,
    input  logic            resume,
    output logic [PC_W-1:0] next_pc,
    output logic            halted,
    output logic [2:0]      stack_depth,
    output logic            stack_overflow,
    output logic            stack_underflow
);

    state_e          state_q, state_d;
    logic            ovf_q, ovf_d;
    logic            unf_q, unf_d;
    logic            run;
    logic            do_ret, do_call;
    logic            push, pop;
    logic            st_full, st_empty;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] st_top;

    assign pc_inc  = pc + PC_W'(1);
    assign run     = !reset && (state_q == RUN);
    assign do_ret  = run && !halt && ret;
    assign do_call = run && !halt && !ret && call;
    assign push    = do_call && !st_full;
    assign pop     = do_ret && !st_empty;

    always_comb begin
        next_pc = pc_inc;
        if (reset)             next_pc = '0;
        else if (!run || halt) next_pc = pc;
        else if (ret)          next_pc = st_empty ? pc_inc : st_top;
        else if (call || jump) next_pc = jump_target;
        else if (branch_taken) next_pc = pc + branch_offset;
    end

    always_comb begin
        state_d = state_q;
        ovf_d   = ovf_q || (do_call && st_full);
        unf_d   = unf_q || (do_ret && st_empty);
        if (run && halt)                        state_d = HALTED;
        else if (state_q == HALTED && resume)   state_d = RUN;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign halted          = (state_q == HALTED);
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

    return_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (PC_W)
    ) u_stack (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .din   (pc_inc),
        .dout  (st_top),
        .depth (stack_depth),
        .full  (st_full),
        .empty (st_empty)
    );

endmodule
